// File: rtl/seg_scan_ctrl.sv
// ----------------------------------------------------------------------------
// seg_scan_ctrl
//   Time-multiplexed scan controller for a bank of common-anode 7-segment
//   digits. One digit is shown per slot of REFRESH_DIV cycles. Each slot opens
//   with GUARD cycles where every anode is off, so that segment data from the
//   previous digit cannot ghost onto the next one. A new value is taken through
//   a load handshake and becomes visible only at a frame boundary, so a frame
//   never shows a mix of old and new digits.
//
// Handshake: a load is accepted on any clock edge where loadIn=1 and
//   readyOut=1. readyOut then stays 0 until the value is committed at the next
//   frame wrap. A loadIn pulse while readyOut=0 has no effect.
//
// Ports
//   clkIn        in   clock
//   rstIn        in   asynchronous, active-high reset
//   loadIn       in   load request, accepted only while readyOut=1
//   valueIn      in   hex value, nibble k is digit k (digit 0 = rightmost)
//   dpIn         in   decimal-point request per digit, 1 = lit
//   blankZeroIn  in   1 = suppress leading-zero digits (sampled live)
//   readyOut     out  1 = a load can be accepted
//   digitOut     out  nibble for the current slot, feeds the digit decoder
//   anodeOut     out  digit enables, active-low
//   decimalOut   out  decimal point for the current slot, active-low
//   dbgStateOut  out  slot FSM state (0 = GUARD, 1 = DRIVE)
// ----------------------------------------------------------------------------
module seg_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 4
) (
  input  logic                    clkIn,
  input  logic                    rstIn,
  input  logic                    loadIn,
  input  logic [4*NUM_DIGITS-1:0] valueIn,
  input  logic [NUM_DIGITS-1:0]   dpIn,
  input  logic                    blankZeroIn,
  output logic                    readyOut,
  output logic [3:0]              digitOut,
  output logic [NUM_DIGITS-1:0]   anodeOut,
  output logic                    decimalOut,
  output logic                    dbgStateOut
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_C  = CNT_W'(GUARD);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {
    S_GUARD = 1'b0,
    S_DRIVE = 1'b1
  } state_t;

  // Registers
  state_t                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic [4*NUM_DIGITS-1:0] r_act_val;
  logic [NUM_DIGITS-1:0]   r_act_dp;
  logic [4*NUM_DIGITS-1:0] r_pend_val;
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic                    r_ready;
  logic [3:0]              r_digit;
  logic [NUM_DIGITS-1:0]   r_anode;
  logic                    r_decimal;

  // Next-state wires
  state_t                  w_state_nxt;
  logic                    w_cnt_last;
  logic                    w_wrap;
  logic                    w_commit;
  logic                    w_accept;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic [IDX_W-1:0]        w_idx_nxt;
  logic [4*NUM_DIGITS-1:0] w_act_val_nxt;
  logic [NUM_DIGITS-1:0]   w_act_dp_nxt;
  logic [4*NUM_DIGITS-1:0] w_pend_val_nxt;
  logic [NUM_DIGITS-1:0]   w_pend_dp_nxt;
  logic                    w_ready_nxt;
  logic [3:0]              w_nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   w_blank;
  logic                    w_zero_run;
  logic [3:0]              w_digit_nxt;
  logic [NUM_DIGITS-1:0]   w_anode_nxt;
  logic                    w_decimal_nxt;

  // Outputs are registered against the *next* cnt/idx, so what appears after
  // an edge always matches the slot position that edge moved into.
  always_comb begin
    w_cnt_last     = (r_cnt == CNT_LAST);
    w_wrap         = w_cnt_last && (r_idx == IDX_LAST);
    w_cnt_nxt      = w_cnt_last ? '0 : r_cnt + 1'b1;
    w_idx_nxt      = r_idx;
    if (w_cnt_last) begin
      w_idx_nxt = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end

    // A pending load is one accepted on an earlier edge (readyOut already 0),
    // so a load accepted on the wrap edge itself waits for the next wrap.
    w_commit       = w_wrap && !r_ready;
    w_accept       = loadIn && r_ready;

    w_act_val_nxt  = r_act_val;
    w_act_dp_nxt   = r_act_dp;
    w_pend_val_nxt = r_pend_val;
    w_pend_dp_nxt  = r_pend_dp;
    w_ready_nxt    = r_ready;
    if (w_commit) begin
      w_act_val_nxt = r_pend_val;
      w_act_dp_nxt  = r_pend_dp;
      w_ready_nxt   = 1'b1;
    end else if (w_accept) begin
      w_pend_val_nxt = valueIn;
      w_pend_dp_nxt  = dpIn;
      w_ready_nxt    = 1'b0;
    end

    for (int k = 0; k < NUM_DIGITS; k++) begin
      w_nib[k] = w_act_val_nxt[4*k +: 4];
    end

    // Scan from the most significant digit down: a digit is a leading zero
    // while every nibble from it upward is zero. Digit 0 always shows.
    w_zero_run = 1'b1;
    w_blank    = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      w_zero_run = w_zero_run && (w_nib[k] == 4'h0);
      w_blank[k] = blankZeroIn && (k != 0) && w_zero_run;
    end

    w_state_nxt   = (w_cnt_nxt < GUARD_C) ? S_GUARD : S_DRIVE;

    // The nibble changes at guard entry, giving the decoder time to settle
    // before the anode turns on.
    w_digit_nxt   = (w_cnt_nxt == '0) ? w_nib[w_idx_nxt] : r_digit;

    w_anode_nxt   = '1;
    w_decimal_nxt = 1'b1;
    if (w_state_nxt == S_DRIVE && !w_blank[w_idx_nxt]) begin
      w_anode_nxt[w_idx_nxt] = 1'b0;
      w_decimal_nxt          = ~w_act_dp_nxt[w_idx_nxt];
    end
  end

  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      r_state    <= S_GUARD;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_act_val  <= '0;
      r_act_dp   <= '0;
      r_pend_val <= '0;
      r_pend_dp  <= '0;
      r_ready    <= 1'b1;
      r_digit    <= 4'h0;
      r_anode    <= '1;
      r_decimal  <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_idx      <= w_idx_nxt;
      r_act_val  <= w_act_val_nxt;
      r_act_dp   <= w_act_dp_nxt;
      r_pend_val <= w_pend_val_nxt;
      r_pend_dp  <= w_pend_dp_nxt;
      r_ready    <= w_ready_nxt;
      r_digit    <= w_digit_nxt;
      r_anode    <= w_anode_nxt;
      r_decimal  <= w_decimal_nxt;
    end
  end

  assign readyOut    = r_ready;
  assign digitOut    = r_digit;
  assign anodeOut    = r_anode;
  assign decimalOut  = r_decimal;
  assign dbgStateOut = r_state;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// ----------------------------------------------------------------------------
// tb_seg_scan_ctrl
//   Directed bench for seg_scan_ctrl with NUM_DIGITS=4, REFRESH_DIV=8, GUARD=2.
//   Inputs change and outputs are sampled on the falling clock edge. The
//   variable k counts rising edges since the last reset release, so the slot
//   position is cnt = k%8, idx = (k/8)%4 and a frame wrap lands on k%32 == 0.
// ----------------------------------------------------------------------------
module tb_seg_scan_ctrl;

  logic        clkIn = 1'b0;
  logic        rstIn = 1'b1;
  logic        loadIn = 1'b0;
  logic [15:0] valueIn = '0;
  logic [3:0]  dpIn = '0;
  logic        blankZeroIn = 1'b0;
  logic        readyOut;
  logic [3:0]  digitOut;
  logic [3:0]  anodeOut;
  logic        decimalOut;
  logic        dbgStateOut;

  int n_cmp = 0;
  int n_err = 0;
  int k = 0;
  logic [15:0] e_val;

  seg_scan_ctrl #(
    .NUM_DIGITS (4),
    .REFRESH_DIV(8),
    .GUARD      (2)
  ) dut (
    .clkIn      (clkIn),
    .rstIn      (rstIn),
    .loadIn     (loadIn),
    .valueIn    (valueIn),
    .dpIn       (dpIn),
    .blankZeroIn(blankZeroIn),
    .readyOut   (readyOut),
    .digitOut   (digitOut),
    .anodeOut   (anodeOut),
    .decimalOut (decimalOut),
    .dbgStateOut(dbgStateOut)
  );

  // clock
  always #5 clkIn = ~clkIn;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s k=%0d: observed %h expected %h", tag, k, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clkIn);
    k++;
  endtask

  // Expected anodes at position kk given which digits are lit (1 = lit).
  function automatic logic [3:0] exp_an(input int kk, input logic [3:0] lit);
    int c;
    int i;
    c = kk % 8;
    i = (kk / 8) % 4;
    if (c < 2 || !lit[i]) return 4'hF;
    return ~(4'b0001 << i);
  endfunction

  // At most one anode low in any cycle.
  always @(negedge clkIn) begin
    if (!rstIn) begin
      n_cmp++;
      assert ($countones(~anodeOut) <= 1) else begin
        n_err++;
        $error("FAIL anode_excl: observed %b expected at most one low", anodeOut);
      end
    end
  end

  initial begin
    // reset and release
    repeat (3) @(negedge clkIn);
    chk("rst_anode", 16'(anodeOut), 16'hF);
    chk("rst_ready", 16'(readyOut), 16'h1);
    rstIn = 1'b0;
    k = 0;
    chk("rst_digit", 16'(digitOut), 16'h0);
    chk("rst_dec", 16'(decimalOut), 16'h1);
    chk("rst_state", 16'(dbgStateOut), 16'h0);

    // Test 1: idle frame, all digits lit with 0
    repeat (32) begin
      chk("t1_anode", 16'(anodeOut), 16'(exp_an(k, 4'hF)));
      chk("t1_digit", 16'(digitOut), 16'h0);
      chk("t1_state", 16'(dbgStateOut), 16'((k % 8) >= 2));
      tick();
    end

    // Test 2: mid-frame load of 12A7, dp on digit 2
    repeat (8) tick();
    loadIn = 1'b1; valueIn = 16'h12A7; dpIn = 4'b0100;
    tick();
    loadIn = 1'b0;
    chk("t2_ready_drop", 16'(readyOut), 16'h0);
    while (k < 64) begin
      chk("t2_hold_digit", 16'(digitOut), 16'h0);
      chk("t2_hold_dec", 16'(decimalOut), 16'h1);
      tick();
    end
    chk("t2_ready_wrap", 16'(readyOut), 16'h1);
    e_val = 16'h12A7;
    repeat (32) begin
      chk("t2_anode", 16'(anodeOut), 16'(exp_an(k, 4'hF)));
      chk("t2_dec", 16'(decimalOut),
          16'((((k / 8) % 4) == 2 && (k % 8) >= 2) ? 1'b0 : 1'b1));
      if (k % 8 == 0) chk("t2_digit", 16'(digitOut), 16'(e_val[((k / 8) % 4) * 4 +: 4]));
      tick();
    end

    // Test 3: second load while pending is ignored
    repeat (2) tick();
    loadIn = 1'b1; valueIn = 16'h4321; dpIn = 4'b0000;
    tick();
    loadIn = 1'b0;
    chk("t3_ready_drop", 16'(readyOut), 16'h0);
    tick();
    loadIn = 1'b1; valueIn = 16'hBEEF; dpIn = 4'b1111;
    tick();
    loadIn = 1'b0;
    chk("t3_ready_held", 16'(readyOut), 16'h0);
    while (k < 128) tick();
    chk("t3_ready_wrap", 16'(readyOut), 16'h1);
    e_val = 16'h4321;
    while (k < 159) begin
      if (k % 8 == 0) chk("t3_digit", 16'(digitOut), 16'(e_val[((k / 8) % 4) * 4 +: 4]));
      if (k % 8 >= 2) chk("t3_dec", 16'(decimalOut), 16'h1);
      tick();
    end

    // Test 4: load accepted exactly on the wrap edge (edge 160)
    loadIn = 1'b1; valueIn = 16'h5678; dpIn = 4'b0000;
    tick();
    loadIn = 1'b0;
    chk("t4_ready_drop", 16'(readyOut), 16'h0);
    chk("t4_digit_old", 16'(digitOut), 16'h1);
    while (k < 191) begin
      if (k % 8 == 0) chk("t4_digit_frame", 16'(digitOut), 16'(e_val[((k / 8) % 4) * 4 +: 4]));
      tick();
    end
    chk("t4_ready_late", 16'(readyOut), 16'h0);
    tick();
    chk("t4_ready_wrap", 16'(readyOut), 16'h1);
    chk("t4_digit_new0", 16'(digitOut), 16'h8);
    tick();

    // Test 5: leading-zero blanking with 0030, then 0000
    blankZeroIn = 1'b1;
    loadIn = 1'b1; valueIn = 16'h0030; dpIn = 4'b0000;
    tick();
    loadIn = 1'b0;
    while (k < 224) tick();
    e_val = 16'h0030;
    repeat (32) begin
      chk("t5_anode_0030", 16'(anodeOut), 16'(exp_an(k, 4'b0011)));
      chk("t5_dec", 16'(decimalOut), 16'h1);
      if (k % 8 == 0) chk("t5_digit", 16'(digitOut), 16'(e_val[((k / 8) % 4) * 4 +: 4]));
      if (k == 226) begin
        loadIn = 1'b1; valueIn = 16'h0000;
      end else begin
        loadIn = 1'b0;
      end
      tick();
    end
    loadIn = 1'b0;
    repeat (32) begin
      chk("t5_anode_zero", 16'(anodeOut), 16'(exp_an(k, 4'b0001)));
      if (k % 8 == 0) chk("t5_digit_zero", 16'(digitOut), 16'h0);
      tick();
    end

    // Test 6: reset while a load is pending, at idx 2
    blankZeroIn = 1'b0;
    loadIn = 1'b1; valueIn = 16'h9999; dpIn = 4'b1111;
    tick();
    loadIn = 1'b0;
    chk("t6_ready_drop", 16'(readyOut), 16'h0);
    while (k < 307) tick();
    chk("t6_anode_pre", 16'(anodeOut), 16'hB);
    chk("t6_state_pre", 16'(dbgStateOut), 16'h1);
    #2 rstIn = 1'b1;
    #1;
    chk("t6_async_anode", 16'(anodeOut), 16'hF);
    chk("t6_async_ready", 16'(readyOut), 16'h1);
    chk("t6_async_digit", 16'(digitOut), 16'h0);
    chk("t6_async_dec", 16'(decimalOut), 16'h1);
    chk("t6_async_state", 16'(dbgStateOut), 16'h0);
    repeat (2) @(negedge clkIn);
    rstIn = 1'b0;
    k = 0;
    repeat (96) begin
      chk("t6_anode_after", 16'(anodeOut), 16'(exp_an(k, 4'hF)));
      chk("t6_ready_after", 16'(readyOut), 16'h1);
      if (k % 8 == 0) chk("t6_digit_after", 16'(digitOut), 16'h0);
      if (k % 8 >= 2) chk("t6_dec_after", 16'(decimalOut), 16'h1);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
